store_commit_buffer: RTL and testbench
======================================

// Module: store_commit_buffer
// PURPOSE
//  Sits directly downstream of the load/store queue and upstream of the memory access controller.
//  Holds committed stores in a FIFO and drains them to the single memory port during idle cycles.
//  Serves loads from memory; optionally serves them from the buffer via store-to-load forwarding.
//  Guarantees that loads never observe stale memory behind a pending store.
// PARAMETERS
//  DEPTH   4   store entries; power of 2, >=2
//  ADDR_W  32  address width; full-width compare, no byte masking
//  DATA_W  32  data width
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-LOW reset
//  st_valid   in   1       store offered by LSQ
//  st_ready   out  1       buffer can accept store (= !full)
//  st_addr    in   ADDR_W  store effective address
//  st_data    in   DATA_W  store data
//  ld_valid   in   1       load request
//  ld_ready   out  1       load can be accepted this cycle
//  ld_addr    in   ADDR_W  load effective address
//  ld_done    out  1       one-cycle pulse; ld_data valid
//  ld_data    out  DATA_W  load result
//  sb_empty   out  1       no stores pending (fence support)
//  mem_read   out  1       registered memory read strobe
//  mem_write  out  1       registered memory write strobe
//  mem_addr   out  ADDR_W  registered memory address
//  mem_wdata  out  DATA_W  registered memory write data
//  mem_rdata  in   DATA_W  read data, valid the cycle after mem_read=1
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - all entries invalid; pointers/count=0; FSM=IDLE.
//   - mem_read=mem_write=ld_done=0; mem_addr=mem_wdata=ld_data=0.
//   - st_ready=1, sb_empty=1; an in-flight load is dropped with no ld_done.
//  FIFO:
//   - rd/wr pointers carry an extra wrap bit; full = count==DEPTH.
//   - Push on st_valid&&st_ready; push and pop in the same cycle leave count unchanged.
//  FSM:
//   - IDLE: ld_valid&&ld_ready accepts the load (address latched). Forward hit -> stay IDLE;
//     miss -> RD.
//   - RD: mem_read=1, mem_addr=latched ld_addr -> WAIT.
//   - WAIT: capture mem_rdata -> ld_done=1 next cycle; -> IDLE.
//   - Miss latency: accept T0, mem_read T1, mem_rdata T2, ld_done T3.
//  ld_ready = (FSM==IDLE) && !full && drain condition (see CONFIGURATION).
//   - Full buffer always drains first, so upstream stores cannot deadlock.
//  Drain:
//   - Pop the head when FSM==IDLE, !sb_empty and no load accepted this cycle.
//   - Next cycle: mem_write=1, mem_addr/mem_wdata = head. Stores drain strictly in FIFO order.
//   - No drain in RD/WAIT. mem_read and mem_write are never high in the same cycle.
//  A store pushed in the same cycle a load is accepted is younger than that load:
//   it is not forwarded and not yet visible to it.
// CONFIGURATION
//  STORE_FWD_EN defined:
//   - Load address compared against all valid entries; youngest match wins.
//   - Hit: ld_done=1 and ld_data=entry data in T1, no mem_read.
//   - Miss: memory read as above. ld_ready ignores sb_empty.
//  STORE_FWD_EN undefined:
//   - No comparators; ld_ready additionally requires sb_empty=1.
//   - Every load goes to memory after all pending stores have drained.
// TESTING
//  1. Reset; store (0x100,0xAA) then (0x104,0xBB), no loads -> mem_write pulses 0x100/0xAA,
//     then 0x104/0xBB in order; sb_empty=1 afterwards.
//  2. Hold st_valid for 6 stores, DEPTH=4, drain allowed -> st_ready low only while count==4;
//     all 6 written in order; ld_ready=0 while full.
//  3. STORE_FWD_EN: stores 0x200=0x11 then 0x200=0x22, load 0x200 -> ld_done at T1,
//     ld_data=0x22, mem_read never asserted.
//  4. Empty buffer, load 0x300, memory returns 0xDEADBEEF -> mem_read T1 addr 0x300;
//     ld_done T3 with 0xDEADBEEF.
//  5. No STORE_FWD_EN: store 0x400=0x5 pending, ld_valid 0x400 -> ld_ready=0 until the
//     mem_write completes; load then reads memory (0x5).
//  6. Drive reset=0 while FSM==WAIT with 2 stores buffered -> all outputs 0 immediately;
//     sb_empty=1; no ld_done after release.

Source files
------------

// File: rtl/store_commit_buffer.sv
// Committed-store FIFO that drains to a single memory port in idle cycles and serves loads.
// Define STORE_FWD_EN to enable store-to-load forwarding from the buffered entries.
module store_commit_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [DATA_W-1:0] st_data_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [ADDR_W-1:0] ld_addr_i,
   output logic              ld_done_o,
   output logic [DATA_W-1:0] ld_data_o,
   output logic              sb_empty_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RD, WAIT} state_t;

   state_t            state_q, state_d;
   logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count;
   logic [PTR_W-1:0]  wr_idx, rd_idx;
   logic [ADDR_W-1:0] addr_mem_q [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   logic              mem_read_q, mem_write_q, ld_done_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, ld_data_q;

   logic              full, empty, push, pop, ld_accept;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   // Pointers carry a wrap bit, so their difference is the occupancy directly.
   assign count  = wr_ptr_q - rd_ptr_q;
   assign full   = (count == FULL_COUNT);
   assign empty  = (count == '0);
   assign wr_idx = wr_ptr_q[PTR_W-1:0];
   assign rd_idx = rd_ptr_q[PTR_W-1:0];

   assign st_ready_o = !full;
   assign sb_empty_o = empty;
   assign push       = st_valid_i && st_ready_o;

`ifdef STORE_FWD_EN
   // Scan oldest to youngest so the last match, the youngest store, wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PTR_W+1)'(i) < count) && (addr_mem_q[rd_idx + PTR_W'(i)] == ld_addr_i)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem_q[rd_idx + PTR_W'(i)];
         end
      end
   end

   assign ld_ready_o = (state_q == IDLE) && !full;
`else
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
   end

   // Without forwarding a load may only see memory once every older store has drained.
   assign ld_ready_o = (state_q == IDLE) && !full && empty;
`endif

   // A full buffer blocks loads, so the head always gets an idle cycle to drain.
   always_comb begin
      state_d   = state_q;
      ld_accept = 1'b0;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            ld_accept = ld_valid_i && ld_ready_o;
            pop       = !empty && !ld_accept;
            if (ld_accept && !fwd_hit) begin
               state_d = RD;
            end
         end
         RD:      state_d = WAIT;
         WAIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ld_done_q   <= 1'b0;
         ld_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         ld_done_q   <= 1'b0;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            mem_write_q <= 1'b1;
            mem_addr_q  <= addr_mem_q[rd_idx];
            mem_wdata_q <= data_mem_q[rd_idx];
         end
         if (ld_accept) begin
            if (fwd_hit) begin
               ld_done_q <= 1'b1;
               ld_data_q <= fwd_data;
            end else begin
               mem_read_q <= 1'b1;
               mem_addr_q <= ld_addr_i;
            end
         end
         if (state_q == WAIT) begin
            ld_done_q <= 1'b1;
            ld_data_q <= mem_rdata_i;
         end
      end
   end

   // Entry storage needs no reset; validity comes from the pointers alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem_q[wr_idx] <= st_addr_i;
         data_mem_q[wr_idx] <= st_data_i;
      end
   end

   assign mem_read_o  = mem_read_q;
   assign mem_write_o = mem_write_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign ld_done_o   = ld_done_q;
   assign ld_data_o   = ld_data_q;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios plus a randomized run
// checked against an architectural memory model (latest older store wins for every load).
module tb_store_commit_buffer;
   localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0, ld_valid = 1'b0;
   logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
   logic        st_ready, ld_ready, ld_done, sb_empty, mem_read, mem_write;
   logic [31:0] ld_data, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;
   int readCount = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] archMem [logic [31:0]];
   logic [31:0] wlogAddr [$];
   logic [31:0] wlogData [$];

   store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr), .st_data_i(st_data),
      .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr),
      .ld_done_o(ld_done), .ld_data_o(ld_data), .sb_empty_o(sb_empty),
      .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memDefault(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] archLookup(input logic [31:0] a);
      return archMem.exists(a) ? archMem[a] : memDefault(a);
   endfunction

   // Memory model: writes land at the edge, read data is valid the cycle after mem_read.
   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr] = mem_wdata;
         wlogAddr.push_back(mem_addr);
         wlogData.push_back(mem_wdata);
      end
      if (mem_read) begin
         readCount++;
         mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : memDefault(mem_addr);
      end else begin
         mem_rdata <= 32'h0BAD_0BAD;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (mem_read && mem_write) begin
            errors++;
            $display("[TB] FAIL port_conflict: got read=%b write=%b required not both", mem_read, mem_write);
         end
      end
   end

   task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic lv, input logic [31:0] la);
      st_valid = sv; st_addr = sa; st_data = sd;
      ld_valid = lv; ld_addr = la;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_st_ready: got %b required 1", st_ready); end
      checks++; if (sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_sb_empty: got %b required 1", sb_empty); end
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ld_ready: got %b required 1", ld_ready); end
      checks++; if ({mem_read, mem_write, ld_done} !== 3'b000) begin errors++; $display("[TB] FAIL rst_strobes: got %b required 000", {mem_read, mem_write, ld_done}); end
      checks++; if ({mem_addr, mem_wdata, ld_data} !== 96'h0) begin errors++; $display("[TB] FAIL rst_data: got %h required 0", {mem_addr, mem_wdata, ld_data}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_drain_order();
      wlogAddr.delete(); wlogData.delete();
      applyStimulus(1, 32'h100, 32'hAA, 0, 0);
      @(posedge clk); #1;
      applyStimulus(1, 32'h104, 32'hBB, 0, 0);
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && !(sb_empty && wlogAddr.size() >= 2); i++) begin
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (wlogAddr.size() != 2) begin
         errors++; $display("[TB] FAIL drain_count: got %0d required 2", wlogAddr.size());
      end else begin
         checks++; if (wlogAddr[0] !== 32'h100 || wlogData[0] !== 32'hAA) begin errors++; $display("[TB] FAIL drain_first: got %h/%h required 100/aa", wlogAddr[0], wlogData[0]); end
         checks++; if (wlogAddr[1] !== 32'h104 || wlogData[1] !== 32'hBB) begin errors++; $display("[TB] FAIL drain_second: got %h/%h required 104/bb", wlogAddr[1], wlogData[1]); end
      end
      checks++; if (sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_sb_empty: got %b required 1", sb_empty); end
   endtask

   task automatic test_full();
      logic [31:0] sd [6];
      logic [31:0] lastData, expData, dataNow;
      logic        expDone, stAcc, ldAcc, sawFull;
      int          pushed, popped, cnt;
      pushed = 0; popped = 0; lastData = '0; expData = '0; expDone = 1'b0; sawFull = 1'b0;
      wlogAddr.delete(); wlogData.delete();
      for (int i = 0; i < 6; i++) sd[i] = $urandom;
      for (int c = 0; c < 60 && (pushed < 6 || expDone); c++) begin
         dataNow = (pushed < 6) ? sd[pushed] : 32'h0;
         applyStimulus(pushed < 6, 32'h500, dataNow, FWD && pushed > 0 && pushed < 6, 32'h500);
         @(negedge clk);
         if (mem_write) popped++;
         cnt = pushed - popped;
         if (cnt == DEPTH) sawFull = 1'b1;
         checks++; if (st_ready !== (cnt != DEPTH)) begin errors++; $display("[TB] FAIL full_st_ready: got %b required %b (count %0d)", st_ready, cnt != DEPTH, cnt); end
         checks++; if (ld_ready !== ((cnt != DEPTH) && (FWD || cnt == 0))) begin errors++; $display("[TB] FAIL full_ld_ready: got %b required %b (count %0d)", ld_ready, (cnt != DEPTH) && (FWD || cnt == 0), cnt); end
         checks++; if (ld_done !== expDone) begin errors++; $display("[TB] FAIL full_ld_done: got %b required %b", ld_done, expDone); end
         if (expDone) begin
            checks++; if (ld_data !== expData) begin errors++; $display("[TB] FAIL full_fwd_data: got %h required %h", ld_data, expData); end
         end
         stAcc = st_valid && st_ready;
         ldAcc = ld_valid && ld_ready;
         expDone = ldAcc;
         expData = lastData;
         if (stAcc) begin lastData = sd[pushed]; pushed++; end
         @(posedge clk); #1;
      end
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 30 && wlogAddr.size() < 6; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (wlogAddr.size() != 6) begin
         errors++; $display("[TB] FAIL full_write_count: got %0d required 6", wlogAddr.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (wlogAddr[i] !== 32'h500 || wlogData[i] !== sd[i]) begin
               errors++; $display("[TB] FAIL full_write_order[%0d]: got %h/%h required 500/%h", i, wlogAddr[i], wlogData[i], sd[i]);
            end
         end
      end
`ifdef STORE_FWD_EN
      checks++; if (sawFull !== 1'b1) begin errors++; $display("[TB] FAIL full_reached: got %b required 1", sawFull); end
`endif
   endtask

   task automatic test_miss();
      mem[32'h300] = 32'hDEAD_BEEF;
      applyStimulus(0, 0, 0, 1, 32'h300);
      @(negedge clk);
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL miss_ld_ready: got %b required 1", ld_ready); end
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("[TB] FAIL miss_t1_read: got %b/%h required 1/300", mem_read, mem_addr); end
      checks++; if (ld_done !== 1'b0) begin errors++; $display("[TB] FAIL miss_t1_done: got %b required 0", ld_done); end
      @(negedge clk);
      checks++; if (mem_read !== 1'b0 || ld_done !== 1'b0) begin errors++; $display("[TB] FAIL miss_t2: got read=%b done=%b required 0/0", mem_read, ld_done); end
      @(negedge clk);
      checks++; if (ld_done !== 1'b1 || ld_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL miss_t3: got %b/%h required 1/deadbeef", ld_done, ld_data); end
      @(negedge clk);
      checks++; if (ld_done !== 1'b0) begin errors++; $display("[TB] FAIL miss_t4_done: got %b required 0", ld_done); end
      @(posedge clk); #1;
   endtask

`ifdef STORE_FWD_EN
   task automatic test_forward();
      int rc;
      wlogAddr.delete(); wlogData.delete();
      mem[32'h2F0] = 32'hCAFE_F00D;
      applyStimulus(1, 32'h200, 32'h11, 1, 32'h2F0);
      @(negedge clk);
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL fwd_t0_ld_ready: got %b required 1", ld_ready); end
      @(posedge clk); #1;
      applyStimulus(1, 32'h200, 32'h22, 0, 0);
      @(negedge clk);
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h2F0) begin errors++; $display("[TB] FAIL fwd_miss_read: got %b/%h required 1/2f0", mem_read, mem_addr); end
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (sb_empty !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("[TB] FAIL fwd_hold: got empty=%b write=%b required 0/0", sb_empty, mem_write); end
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 1, 32'h200);
      @(negedge clk);
      checks++; if (ld_done !== 1'b1 || ld_data !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL fwd_miss_data: got %b/%h required 1/cafef00d", ld_done, ld_data); end
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL fwd_hit_ld_ready: got %b required 1", ld_ready); end
      @(posedge clk); #1;
      rc = readCount;
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (ld_done !== 1'b1 || ld_data !== 32'h22) begin errors++; $display("[TB] FAIL fwd_hit_data: got %b/%h required 1/22", ld_done, ld_data); end
      for (int i = 0; i < 20 && wlogAddr.size() < 2; i++) begin
         @(posedge clk); #1;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (readCount != rc) begin errors++; $display("[TB] FAIL fwd_no_read: got %0d reads required 0", readCount - rc); end
      checks++;
      if (wlogData.size() != 2) begin
         errors++; $display("[TB] FAIL fwd_write_count: got %0d required 2", wlogData.size());
      end else if (wlogData[0] !== 32'h11 || wlogData[1] !== 32'h22) begin
         errors++; $display("[TB] FAIL fwd_write_order: got %h,%h required 11,22", wlogData[0], wlogData[1]);
      end
   endtask
`else
   task automatic test_no_fwd();
      logic accepted, writeSeen, done;
      accepted = 1'b0; writeSeen = 1'b0; done = 1'b0;
      mem[32'h400] = 32'hFFFF_FFFF;
      applyStimulus(1, 32'h400, 32'h5, 0, 0);
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 1, 32'h400);
      for (int c = 0; c < 10 && !accepted; c++) begin
         @(negedge clk);
         if (mem_write) writeSeen = 1'b1;
         if (c == 0) begin
            checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL nofwd_blocked: got %b required 0", ld_ready); end
         end
         if (ld_ready) begin
            accepted = 1'b1;
            checks++; if (!writeSeen) begin errors++; $display("[TB] FAIL nofwd_order: got accept before write required write first"); end
         end
         @(posedge clk); #1;
      end
      applyStimulus(0, 0, 0, 0, 0);
      checks++; if (!accepted) begin errors++; $display("[TB] FAIL nofwd_accept_timeout: got no accept required accept"); end
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge clk);
         if (ld_done) begin
            done = 1'b1;
            checks++; if (ld_data !== 32'h5) begin errors++; $display("[TB] FAIL nofwd_data: got %h required 5", ld_data); end
         end
         @(posedge clk); #1;
      end
      checks++; if (!done) begin errors++; $display("[TB] FAIL nofwd_done_timeout: got no ld_done required 1"); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] expLoad [$];
      logic [31:0] expWA [$];
      logic [31:0] expWD [$];
      logic [31:0] got;
      logic        stAcc, ldAcc;
      archMem = mem;
      wlogAddr.delete(); wlogData.delete();
      for (int c = 0; c < 400; c++) begin
         if (c < 300) begin
            applyStimulus($urandom_range(0, 99) < 45, 32'h600 + 32'($urandom_range(0, 3)) * 4, $urandom,
                          $urandom_range(0, 99) < 35, 32'h600 + 32'($urandom_range(0, 3)) * 4);
         end else begin
            applyStimulus(0, 0, 0, 0, 0);
         end
         @(negedge clk);
         if (ld_done) begin
            checks++;
            if (expLoad.size() == 0) begin
               errors++; $display("[TB] FAIL rand_extra_done: got ld_done=1 required 0");
            end else begin
               got = expLoad.pop_front();
               if (ld_data !== got) begin errors++; $display("[TB] FAIL rand_load_data: got %h required %h", ld_data, got); end
            end
         end
         stAcc = st_valid && st_ready;
         ldAcc = ld_valid && ld_ready;
         if (ldAcc) expLoad.push_back(archLookup(ld_addr));
         if (stAcc) begin
            archMem[st_addr] = st_data;
            expWA.push_back(st_addr);
            expWD.push_back(st_data);
         end
         @(posedge clk); #1;
         if (c >= 300 && expLoad.size() == 0 && sb_empty && !mem_write) break;
      end
      @(posedge clk); #1;
      checks++; if (expLoad.size() != 0) begin errors++; $display("[TB] FAIL rand_pending_loads: got %0d outstanding required 0", expLoad.size()); end
      checks++;
      if (wlogAddr.size() != expWA.size()) begin
         errors++; $display("[TB] FAIL rand_write_count: got %0d required %0d", wlogAddr.size(), expWA.size());
      end else begin
         for (int i = 0; i < expWA.size(); i++) begin
            checks++;
            if (wlogAddr[i] !== expWA[i] || wlogData[i] !== expWD[i]) begin
               errors++; $display("[TB] FAIL rand_write[%0d]: got %h/%h required %h/%h", i, wlogAddr[i], wlogData[i], expWA[i], expWD[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midload();
      applyStimulus(1, 32'h700, 32'h77, 1, 32'h7F0);
      @(negedge clk);
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ld_ready: got %b required 1", ld_ready); end
      @(posedge clk); #1;
      applyStimulus(1, 32'h704, 32'h78, 0, 0);
      @(negedge clk);
      checks++; if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_read: got %b required 1", mem_read); end
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checks++; if (sb_empty !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_buffered: got %b required 0", sb_empty); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if ({mem_read, mem_write, ld_done} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_strobes: got %b required 000", {mem_read, mem_write, ld_done}); end
      checks++; if ({mem_addr, mem_wdata, ld_data} !== 96'h0) begin errors++; $display("[TB] FAIL rstmid_data: got %h required 0", {mem_addr, mem_wdata, ld_data}); end
      checks++; if (sb_empty !== 1'b1 || st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_flags: got empty=%b st_ready=%b required 1/1", sb_empty, st_ready); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (ld_done !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after: got done=%b write=%b read=%b required 0/0/0", ld_done, mem_write, mem_read); end
      end
      checks++; if (sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_empty_after: got %b required 1", sb_empty); end
   endtask

   initial begin
      $display("[TB] store_commit_buffer bench, forwarding=%0d", FWD);
      test_reset();
      test_drain_order();
      test_full();
      test_miss();
`ifdef STORE_FWD_EN
      test_forward();
`else
      test_no_fwd();
`endif
      test_random();
      test_reset_midload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
